// File: rtl/frame_stream_if.sv
// rtl/frame_stream_if.sv - pixel stream handshake bundle between reader and pipeline
interface frame_stream_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tdata_out;
    logic             tvalid_out;
    logic             tready_in;
    logic             tlast_out;

    modport master (
        output tdata_out,
        output tvalid_out,
        output tlast_out,
        input  tready_in
    );

    modport slave (
        input  tdata_out,
        input  tvalid_out,
        input  tlast_out,
        output tready_in
    );
endinterface

// File: rtl/frame_stream_reader.sv
// rtl/frame_stream_reader.sv - streams one frame from a BRAM read port through a 4-entry FIFO
module frame_stream_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start_in,
    output logic               busy_out,
    output logic [14:0]        addr_read_out,
    input  logic [WIDTH-1:0]   data_read_in,
    frame_stream_if.master     strm,
    output logic               done_out
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [14:0] LAST = 15'(DEPTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       inflight_q;
    logic [WIDTH-1:0] fifo_mem [4];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [2:0]       count;
    logic [14:0]      beat_cnt;
    logic [2:0]       pending;
    logic             issue;
    logic             push;
    logic             pop;

    assign push            = inflight_q[1];
    assign pop             = strm.tvalid_out && strm.tready_in;
    assign strm.tvalid_out = (count != 3'd0);
    assign strm.tdata_out  = fifo_mem[rd_ptr];
    assign strm.tlast_out  = strm.tvalid_out && (beat_cnt == LAST);

    // Every issued read already owns a FIFO slot, so the FIFO can never overflow.
    assign pending = count + {2'b00, inflight_q[0]} + {2'b00, inflight_q[1]};

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = RUN;
                    issue   = 1'b1;
                end
            end
            RUN: begin
                if (addr_read_out == LAST) begin
                    state_d = DRAIN;
                end else if (pending < 3'd4) begin
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                if (pop && (beat_cnt == LAST)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            addr_read_out <= 15'd0;
            inflight_q    <= 2'b00;
            beat_cnt      <= 15'd0;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_out   <= (state_d != IDLE);
            done_out   <= (state_d == DONE);
            // [0] tracks the registered address, [1] the BRAM output register.
            inflight_q <= {inflight_q[0], issue};
            if (issue) begin
                addr_read_out <= (state_q == IDLE) ? 15'd0 : addr_read_out + 15'd1;
            end
            if ((state_q == IDLE) && start_in) begin
                beat_cnt <= 15'd0;
            end else if (pop) begin
                beat_cnt <= beat_cnt + 15'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= data_read_in;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            if (push && !pop) begin
                count <= count + 3'd1;
            end else if (!push && pop) begin
                count <= count - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_frame_stream_reader.sv
// tb/tb_frame_stream_reader.sv - randomized self-checking bench for frame_stream_reader
module tb_frame_stream_reader;
    localparam int DEP [3] = '{16, 256, 1};

    logic       clk = 1'b0;
    logic       rst   [3];
    logic       start [3];
    logic       rdy   [3];
    logic       busy  [3];
    logic       done  [3];
    logic       tv    [3];
    logic       tl    [3];
    logic [7:0] td    [3];
    logic [7:0] rdata [3];
    logic [14:0] addr [3];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int beat_idx [3] = '{0, 0, 0};
    int done_cnt [3] = '{0, 0, 0};
    int tl_cnt   [3] = '{0, 0, 0};
    int tl_cyc   [3] = '{0, 0, 0};
    int done_cyc [3] = '{0, 0, 0};
    int last_hs  [3] = '{0, 0, 0};
    bit was_done [3] = '{0, 0, 0};
    int hs_q [3][$];

    frame_stream_if #(.WIDTH(8)) s0 ();
    frame_stream_if #(.WIDTH(8)) s1 ();
    frame_stream_if #(.WIDTH(8)) s2 ();

    frame_stream_reader #(.WIDTH(8), .DEPTH(16)) dut0 (
        .clk_in(clk), .rst_in(rst[0]), .start_in(start[0]), .busy_out(busy[0]),
        .addr_read_out(addr[0]), .data_read_in(rdata[0]), .strm(s0), .done_out(done[0]));
    frame_stream_reader #(.WIDTH(8), .DEPTH(256)) dut1 (
        .clk_in(clk), .rst_in(rst[1]), .start_in(start[1]), .busy_out(busy[1]),
        .addr_read_out(addr[1]), .data_read_in(rdata[1]), .strm(s1), .done_out(done[1]));
    frame_stream_reader #(.WIDTH(8), .DEPTH(1)) dut2 (
        .clk_in(clk), .rst_in(rst[2]), .start_in(start[2]), .busy_out(busy[2]),
        .addr_read_out(addr[2]), .data_read_in(rdata[2]), .strm(s2), .done_out(done[2]));

    assign s0.tready_in = rdy[0];
    assign s1.tready_in = rdy[1];
    assign s2.tready_in = rdy[2];
    assign tv[0] = s0.tvalid_out;  assign tl[0] = s0.tlast_out;  assign td[0] = s0.tdata_out;
    assign tv[1] = s1.tvalid_out;  assign tl[1] = s1.tlast_out;  assign td[1] = s1.tdata_out;
    assign tv[2] = s2.tvalid_out;  assign tl[2] = s2.tlast_out;  assign td[2] = s2.tdata_out;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pix(input int i, input int a);
        case (i)
            0:       return (a + 16) & 255;
            1:       return a & 255;
            default: return 8'hA5;
        endcase
    endfunction

    // Frame BRAM read ports with one cycle of read latency.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            rdata[i] <= 8'(pix(i, int'(addr[i])));
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input int i);
        check("rst_busy", int'(busy[i]), 0);
        check("rst_done", int'(done[i]), 0);
        check("rst_tvalid", int'(tv[i]), 0);
        check("rst_tlast", int'(tl[i]), 0);
        check("rst_tdata", int'(td[i]), 0);
        check("rst_addr", int'(addr[i]), 0);
    endtask

    task automatic wait_done(input int i, input int base, input int budget);
        int n = 0;
        while (done_cnt[i] == base && n < budget) begin
            tick();
            n++;
        end
        check("frame_timeout", int'(done_cnt[i] > base), 1);
        repeat (2) tick();
    endtask

    // Reference scoreboard: beat k of a frame must carry pixel k, tlast only on the
    // final pixel, done one cycle after the final handshake, at most 4 reads outstanding.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                beat_idx[i] = 0;
                was_done[i] = 1'b0;
            end else begin
                if (was_done[i]) check("busy_after_done", int'(busy[i]), 0);
                was_done[i] = done[i];
                if (busy[i]) check("outstanding_le4", int'((int'(addr[i]) + 1 - beat_idx[i]) <= 4), 1);
                check("tlast", int'(tl[i]), int'(tv[i] && (beat_idx[i] == DEP[i] - 1)));
                if (tv[i] && rdy[i]) begin
                    check("tdata", int'(td[i]), pix(i, beat_idx[i]));
                    if (tl[i]) begin
                        tl_cnt[i]++;
                        tl_cyc[i] = cyc;
                    end
                    hs_q[i].push_back(cyc);
                    last_hs[i] = cyc;
                    beat_idx[i]++;
                end
                if (done[i]) begin
                    check("done_latency", cyc - last_hs[i], 1);
                    check("frame_beats", beat_idx[i], DEP[i]);
                    done_cnt[i]++;
                    done_cyc[i] = cyc;
                    beat_idx[i] = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int b;
        int tb;
        int n;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            start[i] = 1'b0;
            rdy[i] = 1'b0;
        end
        repeat (3) tick();
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_reset(i);

        // Continuous ready, DEPTH=16.
        hs_q[0].delete();
        b = done_cnt[0];
        tick();
        s = cyc;
        start[0] = 1'b1;
        rdy[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_done(0, b, 100);
        check("a_beats", hs_q[0].size(), 16);
        for (int k = 0; k < 16; k++) begin
            if (k < hs_q[0].size()) check("a_gapfree", hs_q[0][k] - s, 3 + k);
        end
        check("a_tlast_cycle", tl_cyc[0] - s, 18);
        check("a_done_cycle", done_cyc[0] - s, 19);

        // Backpressure: ready low in cycles 5..14.
        hs_q[0].delete();
        b = done_cnt[0];
        for (int c = 0; c < 60; c++) begin
            tick();
            if (c == 0) s = cyc;
            start[0] = (c == 0);
            rdy[0] = !(c >= 5 && c <= 14);
            @(negedge clk);
            if (c >= 6 && c <= 14) check("b_addr_hold", int'(addr[0]), 5);
        end
        check("b_frames", done_cnt[0] - b, 1);
        check("b_beats", hs_q[0].size(), 16);

        // Random ready over a 256-pixel frame.
        hs_q[1].delete();
        b = done_cnt[1];
        tb = tl_cnt[1];
        tick();
        start[1] = 1'b1;
        rdy[1] = 1'($urandom_range(0, 1));
        tick();
        start[1] = 1'b0;
        n = 0;
        while (done_cnt[1] == b && n < 3000) begin
            rdy[1] = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("c_timeout", int'(done_cnt[1] > b), 1);
        rdy[1] = 1'b1;
        repeat (3) tick();
        check("c_done_count", done_cnt[1] - b, 1);
        check("c_tlast_count", tl_cnt[1] - tb, 1);
        check("c_beats", hs_q[1].size(), 256);

        // Starts while busy and in DONE are ignored; start right after done restarts.
        hs_q[0].delete();
        b = done_cnt[0];
        for (int c = 0; c < 50; c++) begin
            tick();
            if (c == 0) s = cyc;
            start[0] = (c == 0 || c == 5 || c == 19 || c == 20);
            rdy[0] = 1'b1;
            @(negedge clk);
            if (c == 19) check("d_done_c19", int'(done[0]), 1);
            if (c == 20) check("d_idle_c20", int'(busy[0]), 0);
            if (c == 21) check("d_busy_c21", int'(busy[0]), 1);
        end
        check("d_frames", done_cnt[0] - b, 2);
        check("d_beats", hs_q[0].size(), 32);
        if (hs_q[0].size() > 16) begin
            check("d_first_beat", hs_q[0][0] - s, 3);
            check("d_restart_beat", hs_q[0][16] - s, 23);
        end

        // Reset mid-frame after beat 7 with the FIFO holding data.
        hs_q[0].delete();
        b = done_cnt[0];
        for (int c = 0; c < 25; c++) begin
            tick();
            if (c == 0) s = cyc;
            start[0] = (c == 0);
            rdy[0] = (c != 11);
            rst[0] = (c == 11);
            @(negedge clk);
            if (c == 11) begin
                check("e_beats_before_rst", hs_q[0].size(), 8);
                check("e_fifo_nonempty", int'(tv[0]), 1);
            end
            if (c == 12) check_reset(0);
            if (c >= 12) check("e_no_beats", int'(tv[0]), 0);
        end
        check("e_no_done", done_cnt[0] - b, 0);
        hs_q[0].delete();
        b = done_cnt[0];
        tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_done(0, b, 100);
        check("e_restart_beats", hs_q[0].size(), 16);

        // Single-pixel frame.
        hs_q[2].delete();
        b = done_cnt[2];
        rdy[2] = 1'b1;
        tick();
        s = cyc;
        start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        wait_done(2, b, 50);
        check("f_beats", hs_q[2].size(), 1);
        if (hs_q[2].size() > 0) check("f_first_beat", hs_q[2][0] - s, 3);
        check("f_tlast_cycle", tl_cyc[2] - s, 3);
        check("f_done_cycle", done_cyc[2] - s, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_stream_reader.md
# frame_stream_reader

Reads one frame of pixels, addresses 0 to DEPTH-1, out of a simple dual-port frame BRAM through its synchronous read port. Presents the pixels in order as a valid/ready stream with a last-pixel marker. Absorbs the BRAM's one-cycle read latency and downstream backpressure with a small internal FIFO. Sits between the frame buffer's read port and the display/processing pipeline, on the read-port clock.

## Interface
Parameters:
- WIDTH, 8, pixel width in bits; matches the BRAM data width.
- DEPTH, 256, pixels per frame; 1 ≤ DEPTH ≤ 32768.

Ports:
- clk_in  input  1  the single clock; also drives the BRAM read port.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  single-cycle request to stream one frame; ignored while busy_out=1.
- busy_out  output  1  high from the cycle after an accepted start until the cycle done_out pulses, inclusive.
- addr_read_out  output  15  registered BRAM read address.
- data_read_in  input  WIDTH  BRAM read data; valid one cycle after the address is presented.
- tdata_out  output  WIDTH  pixel data.
- tvalid_out  output  1  tdata_out/tlast_out valid.
- tready_in  input  1  downstream accepts a beat when tvalid_out && tready_in.
- tlast_out  output  1  high with pixel DEPTH-1.
- done_out  output  1  one-cycle pulse after the last beat handshakes.

## Operation
- States:
  - IDLE. start_in moves the block to RUN, sets the read address to 0 and sets the beat counter to 0.
  - RUN. Issues reads. After the read for address DEPTH-1 is issued, moves to DRAIN.
  - DRAIN. Waits for all outstanding reads and buffered pixels to be sent. On the handshake of beat DEPTH-1, moves to DONE.
  - DONE. Lasts one cycle. done_out=1, then returns to IDLE.
- Read issue, RUN only:
  - A read is issued in a cycle by presenting the next address on addr_read_out and marking it in a 2-stage in-flight valid pipe.
  - The in-flight pipe matches the registered address plus the BRAM output register.
  - A read is issued only if FIFO occupancy + in-flight count + 1 ≤ 4 (FIFO depth 4). The FIFO therefore never overflows and never drops data.
- When no read is issued, addr_read_out holds its last value. Reads of a held address are discarded because their in-flight bit is 0.
- Returned data is written into the FIFO when its in-flight bit reaches the end of the pipe.
- The FIFO head drives tdata_out, tvalid_out = FIFO non-empty.
- A pop occurs on tvalid_out && tready_in. A write and a pop in the same cycle are both performed and occupancy is unchanged.
- tlast_out = tvalid_out && (beat counter == DEPTH-1). The beat counter increments on each handshake.
- Address arithmetic is 15-bit unsigned. The read address never exceeds DEPTH-1 and never wraps within a frame.
- start_in while busy is ignored, with no queuing. start_in in the DONE cycle is also ignored. The earliest accepted restart is in the IDLE cycle after done_out.
- Reset, including mid-frame, has the same effect in every case:
  - state = IDLE, FIFO empty, in-flight pipe cleared, counters = 0.
  - addr_read_out = 0, tvalid_out = 0, tlast_out = 0, busy_out = 0, done_out = 0, tdata_out = 0.
  - Data from the BRAM after reset is discarded.

## Timing
- Cycle 0: start_in=1 in IDLE.
- Cycle 1: busy_out=1, addr_read_out=0.
- Cycle 2: data_read_in = mem[0].
- Cycle 3: tvalid_out=1, tdata_out = mem[0].
- Latency from start to the first valid beat is 3 cycles.
- With tready_in held high, beats are gap-free at 1 per cycle. Beat k appears in cycle 3+k.
- When tready_in goes low, at most 4 pixels are held in the FIFO and further issue stalls within 1 cycle. When tready_in returns high, the stream resumes with no duplicate or missing pixels.
- done_out is high the cycle after the beat DEPTH-1 handshake. busy_out falls the cycle after done_out.
- With DEPTH=256 and continuous ready: last beat in cycle 258, done_out in cycle 259, idle in cycle 260.
- All outputs are registered, except tvalid_out, tdata_out and tlast_out, which are driven from FIFO registers with no combinational path from tready_in.

## Test plan
- DEPTH=16, mem[i]=i+0x10, tready_in constantly 1, start in cycle 0:
  - beats 0x10..0x1F in cycles 3..18, gap-free.
  - tlast_out only in cycle 18, done_out in cycle 19.
- Backpressure, DEPTH=16, tready_in low in cycles 5..14:
  - the full sequence 0x10..0x1F arrives in order with no duplicates.
  - FIFO occupancy + in-flight count never exceeds 4.
  - addr_read_out stops advancing by cycle 6.
- Random tready_in (50%) over DEPTH=256 with mem[i]=i[7:0]: scoreboard matches all 256 beats; exactly one tlast_out and one done_out.
- start_in pulsed in cycles 0, 5 and in the DONE cycle: exactly one frame is streamed. A start in the cycle after done_out begins a second frame, with first beat 3 cycles later.
- rst_in asserted for 1 cycle mid-frame, after beat 7 and with the FIFO non-empty:
  - next cycle all outputs are at reset values and no further beats appear.
  - a new start streams from pixel 0.
- DEPTH=1:
  - first beat carries mem[0] with tlast_out=1.
  - done_out one cycle after the handshake.
